timekeeper_core: RTL
====================

TIMEKEEPER_CORE -- requirements
Module: timekeeper_core

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock cycles per second (prescaler terminal count + 1); SHALL be >= 2.
REQ-002 Parameter ALARM_SEC, default 60, seconds the alarm output stays asserted once triggered; SHALL be 1..255.
REQ-003 CLOCK_50  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 key_mode  in  1  debounced level; a rising edge advances the setting state.
REQ-006 key_inc  in  1  debounced level; a rising edge increments the selected field.
REQ-007 key_dec  in  1  debounced level; a rising edge decrements the selected field.
REQ-008 fmt12  in  1  1 = 12-hour display, 0 = 24-hour display; affects outputs only.
REQ-009 alarm_en  in  1  1 = alarm armed.
REQ-010 hh_bcd, mm_bcd, ss_bcd  out  8 each  displayed hours/minutes/seconds as two BCD digits, tens digit in [7:4].
REQ-011 pm  out  1  high when fmt12=1 and the displayed time is 12:00:00-23:59:59.
REQ-012 state  out  3  current setting state encoding (see REQ-016).
REQ-013 tick_1hz  out  1  one-cycle pulse at each prescaler terminal count.
REQ-014 alarm  out  1  alarm active.

Function
REQ-015 Edge detect: each key SHALL be registered once; an event is current=1 and previous=0; events are visible to the FSM one cycle after the input edge.
REQ-016 FSM states and encodings: RUN=0, SET_H=1, SET_M=2, SET_S=3, SET_AH=4, SET_AM=5; a mode event SHALL go RUN->SET_H->SET_M->SET_S->SET_AH->SET_AM->RUN; encodings 6-7 SHALL go to RUN on the next cycle.
REQ-017 Same-cycle key events: mode SHALL take priority and inc/dec SHALL be ignored; simultaneous inc and dec SHALL be ignored.
REQ-018 Prescaler SHALL count 0..CLK_HZ-1 and wrap; tick_1hz SHALL be high in the cycle where the count equals CLK_HZ-1.
REQ-019 The prescaler SHALL run only in RUN and SET_AH/SET_AM; in SET_H/SET_M/SET_S it SHALL be held at 0 and tick_1hz SHALL be 0.
REQ-020 Time SHALL be stored as binary 24-hour values h 0..23, m 0..59, s 0..59.
REQ-021 On tick: s increments; s 59->0 carries into m; m 59->0 carries into h; h 23->0; 23:59:59 SHALL become 00:00:00 in one cycle.
REQ-022 In SET_H/SET_M/SET_S, inc/dec SHALL change only the selected field, modulo 24/60/60, with no carry (h 23+1=0, m 0-1=59).
REQ-023 In SET_AH/SET_AM, inc/dec SHALL change alarm hour (mod 24) or alarm minute (mod 60); time keeps running.
REQ-024 Display conversion SHALL be combinational from the registers (zero latency).
REQ-025 With fmt12=1, displayed hour SHALL be 12 for h=0 and h=12, and h-12 for h=13..23.
REQ-026 In SET_AH/SET_AM, hh_bcd/mm_bcd SHALL show alarm hour/minute and ss_bcd SHALL show 0x00.
REQ-027 Alarm trigger: in RUN with alarm_en=1, a tick that produces s=0 with h:m equal to the alarm setting SHALL set alarm in the following cycle and load the remaining count with ALARM_SEC.
REQ-028 While alarm=1, each tick SHALL decrement the remaining count; alarm SHALL clear on the tick that reaches 0, on any key event, or when alarm_en=0.
REQ-029 Leaving RUN SHALL clear alarm.

Reset
REQ-030 On reset: state=RUN; time=00:00:00; alarm setting=00:00; prescaler=0; alarm=0; tick_1hz=0; key history registers=0.
REQ-031 Reset SHALL take priority over all events in the same cycle, including during a SET state or an active alarm.

Verification (CLK_HZ=4, ALARM_SEC=3)
REQ-032 Release reset, hold keys low, run 8 cycles -> tick_1hz pulses at cycles 4 and 8; ss_bcd=0x02.
REQ-033 Preload 23:59:59, run to the next tick -> hh/mm/ss = 0x00/0x00/0x00 in one cycle; with fmt12=1, hh_bcd=0x12 and pm=0.
REQ-034 From RUN, one mode pulse then 25 inc pulses -> state=1, hh_bcd=0x01, time not advancing; 5 more mode pulses -> state=0.
REQ-035 Press mode and inc in the same cycle -> state advances one step and the field is unchanged; press inc and dec together in SET_M -> minute unchanged.
REQ-036 Alarm set to 00:01, alarm_en=1, run from 00:00:00 -> alarm rises one cycle after the 00:01:00 tick and falls on the 3rd subsequent tick; repeat and press key_inc -> alarm cleared 2 cycles after the key edge.
REQ-037 Assert reset during SET_S with alarm active -> all outputs match REQ-030 on the next cycle.

Source files
------------

// File: rtl/timekeeper_core.sv
// Digital clock core: 1 Hz prescaler, 24-hour timekeeping with key-driven setting modes,
// alarm compare with a timed alarm output, and combinational BCD display (12/24-hour).
module timekeeper_core #(
   parameter int CLK_HZ    = 50000000,
   parameter int ALARM_SEC = 60
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic       key_dec,
   input  logic       fmt12,
   input  logic       alarm_en,
   output logic [7:0] hh_bcd,
   output logic [7:0] mm_bcd,
   output logic [7:0] ss_bcd,
   output logic       pm,
   output logic [2:0] state,
   output logic       tick_1hz,
   output logic       alarm
);

   localparam int CNT_W = $clog2(CLK_HZ);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLK_HZ - 1);

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      SET_H  = 3'd1,
      SET_M  = 3'd2,
      SET_S  = 3'd3,
      SET_AH = 3'd4,
      SET_AM = 3'd5
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [4:0]       h_reg, ah_reg;
   logic [5:0]       m_reg, s_reg, am_reg;
   logic [7:0]       rem_reg;
   logic             alarm_reg;
   logic             mode_reg, mode_prev_reg;
   logic             inc_reg, inc_prev_reg;
   logic             dec_reg, dec_prev_reg;

   function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
      if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
      return (v == 6'd0) ? 6'd59 : v - 6'd1;
   endfunction

   function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
      if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
      return (v == 5'd0) ? 5'd23 : v - 5'd1;
   endfunction

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

   // Key events come from the registered level against its one-cycle history.
   logic ev_mode, ev_inc, ev_dec, any_ev, adj, adj_up;
   assign ev_mode = mode_reg & ~mode_prev_reg;
   assign ev_inc  = inc_reg & ~inc_prev_reg;
   assign ev_dec  = dec_reg & ~dec_prev_reg;
   assign any_ev  = ev_mode | ev_inc | ev_dec;
   assign adj     = ~ev_mode & (ev_inc ^ ev_dec);
   assign adj_up  = ev_inc;

   logic running, tick;
   assign running  = (state_reg == RUN) || (state_reg == SET_AH) || (state_reg == SET_AM);
   assign tick     = running && (cnt_reg == CNT_TC);
   assign tick_1hz = tick;

   logic [4:0] h_nt;
   logic [5:0] m_nt, s_nt;
   logic       trig;
   always_comb begin
      s_nt = (s_reg == 6'd59) ? 6'd0 : s_reg + 6'd1;
      m_nt = m_reg;
      h_nt = h_reg;
      if (s_reg == 6'd59) begin
         m_nt = (m_reg == 6'd59) ? 6'd0 : m_reg + 6'd1;
         if (m_reg == 6'd59) h_nt = (h_reg == 5'd23) ? 5'd0 : h_reg + 5'd1;
      end
      trig = tick && (state_reg == RUN) && alarm_en && (s_nt == 6'd0)
             && (h_nt == ah_reg) && (m_nt == am_reg);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_reg     <= RUN;
         cnt_reg       <= '0;
         h_reg         <= 5'd0;
         m_reg         <= 6'd0;
         s_reg         <= 6'd0;
         ah_reg        <= 5'd0;
         am_reg        <= 6'd0;
         rem_reg       <= 8'd0;
         alarm_reg     <= 1'b0;
         mode_reg      <= 1'b0;
         mode_prev_reg <= 1'b0;
         inc_reg       <= 1'b0;
         inc_prev_reg  <= 1'b0;
         dec_reg       <= 1'b0;
         dec_prev_reg  <= 1'b0;
      end else begin
         mode_reg      <= key_mode;
         mode_prev_reg <= mode_reg;
         inc_reg       <= key_inc;
         inc_prev_reg  <= inc_reg;
         dec_reg       <= key_dec;
         dec_prev_reg  <= dec_reg;

         if (!running)  cnt_reg <= '0;
         else if (tick) cnt_reg <= '0;
         else           cnt_reg <= cnt_reg + CNT_W'(1);

         case (state_reg)
            RUN:     if (ev_mode) state_reg <= SET_H;
            SET_H:   if (ev_mode) state_reg <= SET_M;
            SET_M:   if (ev_mode) state_reg <= SET_S;
            SET_S:   if (ev_mode) state_reg <= SET_AH;
            SET_AH:  if (ev_mode) state_reg <= SET_AM;
            SET_AM:  if (ev_mode) state_reg <= RUN;
            default: state_reg <= RUN;
         endcase

         // Ticks only occur in running states, so they never collide with time setting.
         if (tick) begin
            h_reg <= h_nt;
            m_reg <= m_nt;
            s_reg <= s_nt;
         end else if (adj) begin
            if (state_reg == SET_H) h_reg <= step24(h_reg, adj_up);
            if (state_reg == SET_M) m_reg <= step60(m_reg, adj_up);
            if (state_reg == SET_S) s_reg <= step60(s_reg, adj_up);
         end
         if (adj && state_reg == SET_AH) ah_reg <= step24(ah_reg, adj_up);
         if (adj && state_reg == SET_AM) am_reg <= step60(am_reg, adj_up);

         if (any_ev || !alarm_en || state_reg != RUN) begin
            alarm_reg <= 1'b0;
            rem_reg   <= 8'd0;
         end else if (trig) begin
            alarm_reg <= 1'b1;
            rem_reg   <= 8'(ALARM_SEC);
         end else if (alarm_reg && tick) begin
            rem_reg <= rem_reg - 8'd1;
            if (rem_reg == 8'd1) alarm_reg <= 1'b0;
         end
      end
   end

   assign state = state_reg;
   assign alarm = alarm_reg;

   logic       show_alarm;
   logic [4:0] disp_h, hour12;
   always_comb begin
      show_alarm = (state_reg == SET_AH) || (state_reg == SET_AM);
      disp_h     = show_alarm ? ah_reg : h_reg;
      hour12     = disp_h;
      if (disp_h == 5'd0)      hour12 = 5'd12;
      else if (disp_h > 5'd12) hour12 = disp_h - 5'd12;
      pm     = fmt12 && (disp_h >= 5'd12);
      hh_bcd = to_bcd({1'b0, fmt12 ? hour12 : disp_h});
      mm_bcd = to_bcd(show_alarm ? am_reg : m_reg);
      ss_bcd = show_alarm ? 8'h00 : to_bcd(s_reg);
   end

endmodule
